sha256_msg_sched: RTL and testbench

Message-schedule and sequencing front end for the SHA-256 core. It accepts 512-bit chunks as a stream of sixteen 32-bit big-endian words and expands them into W[0..63]. It drives the round constant K[t] and the clr/update controls consumed by the compression loop. Each round occupies a 4-cycle slot, so a chunk takes 256 cycles.

---
 rtl/sha256_msg_sched.sv | 190 +++++++++++++++++++
 tb/tb_sha256_msg_sched.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule / round sequencer: streams W[t], K[t] and clr/update/done to the compression loop.
// Latency: 16 LOAD cycles per chunk, then 64 rounds x 4-cycle slots (256 cycles); 272 cycles per chunk back-to-back.
// Backpressure: word_ready_o is high only in LOAD; words offered during RUN are not consumed and must be held.
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   word_valid_i/word_ready_o/word_i/last_i
//                            input word handshake; last_i sampled with word 15 only
//   w_o, k_o                 W[t] and K[t], held for the 4 cycles of round slot t
//   clr_o                    pulse after word 0 of a new message is accepted
//   update_o                 pulse in the last cycle of round 63
//   busy_o                   high while rounds run
//   done_o                   pulse the cycle after update_o of a final chunk
module sha256_msg_sched (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        word_valid_i,
  output logic        word_ready_o,
  input  logic [31:0] word_i,
  input  logic        last_i,
  output logic [31:0] w_o,
  output logic [31:0] k_o,
  output logic        clr_o,
  output logic        update_o,
  output logic        busy_o,
  output logic        done_o
);

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [31:0] K_ROM [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] sigma0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sigma1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  state_e      state_q, state_d;
  logic [3:0]  cnt_q;
  logic [5:0]  t_q;
  logic [1:0]  slot_q;
  logic        first_q;
  logic        last_q;
  logic [31:0] w_q, k_q;
  logic        busy_q, clr_q, done_q;

  // 16-entry circular window: while round t is running it holds W[t-15..t]
  // (or the raw chunk words before round 16), indexed by round mod 16.
  logic [31:0] buf_q [16];

  logic        accept;
  logic        slot_end;
  logic        chunk_end;
  logic [5:0]  t_nxt;
  logic [3:0]  i_nxt;
  logic [31:0] w_new;
  logic [31:0] w_sched;
  logic        sched_we;

  // Next-state and handshake/strobe decode.
  always_comb begin
    state_d      = state_q;
    accept       = 1'b0;
    slot_end     = 1'b0;
    chunk_end    = 1'b0;
    word_ready_o = 1'b0;
    update_o     = 1'b0;
    case (state_q)
      LOAD: begin
        word_ready_o = 1'b1;
        accept       = word_valid_i;
        if (word_valid_i && (cnt_q == 4'd15)) begin
          state_d = RUN;
        end
      end
      RUN: begin
        slot_end  = (slot_q == 2'd3);
        chunk_end = slot_end && (t_q == 6'd63);
        update_o  = chunk_end;
        if (chunk_end) begin
          state_d = LOAD;
        end
      end
    endcase
  end

  // Schedule word for the round about to start. Indices are mod 16, so
  // n-15 is the slot after n and n-16 is slot n itself (read before the
  // overwrite on the same edge).
  always_comb begin
    t_nxt    = t_q + 6'd1;
    i_nxt    = t_nxt[3:0];
    w_new    = sigma1(buf_q[i_nxt - 4'd2]) + buf_q[i_nxt - 4'd7]
             + sigma0(buf_q[i_nxt + 4'd1]) + buf_q[i_nxt];
    w_sched  = (t_nxt < 6'd16) ? buf_q[i_nxt] : w_new;
    sched_we = slot_end && !chunk_end && (t_nxt >= 6'd16);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= LOAD;
      cnt_q   <= 4'd0;
      t_q     <= 6'd0;
      slot_q  <= 2'd0;
      first_q <= 1'b1;
      last_q  <= 1'b0;
      w_q     <= 32'd0;
      k_q     <= 32'd0;
      busy_q  <= 1'b0;
      clr_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      clr_q   <= accept && (cnt_q == 4'd0) && first_q;
      done_q  <= chunk_end && last_q;

      if (accept) begin
        cnt_q <= cnt_q + 4'd1;
        if (cnt_q == 4'd0) begin
          first_q <= 1'b0;
        end
        if (cnt_q == 4'd15) begin
          // Word 0 already sits in slot 0, so round 0 can be presented
          // on the very next cycle.
          last_q <= last_i;
          t_q    <= 6'd0;
          slot_q <= 2'd0;
          w_q    <= buf_q[0];
          k_q    <= K_ROM[0];
          busy_q <= 1'b1;
        end
      end

      if (state_q == RUN) begin
        slot_q <= slot_q + 2'd1;
        if (slot_end && !chunk_end) begin
          t_q <= t_nxt;
          w_q <= w_sched;
          k_q <= K_ROM[t_nxt];
        end
        if (chunk_end) begin
          busy_q <= 1'b0;
          cnt_q  <= 4'd0;
          if (last_q) begin
            first_q <= 1'b1;
          end
        end
      end
    end
  end

  // Data store carries no reset: every entry is rewritten by LOAD before use.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      buf_q[cnt_q] <= word_i;
    end else if (sched_we) begin
      buf_q[i_nxt] <= w_new;
    end
  end

  assign w_o    = w_q;
  assign k_o    = k_q;
  assign busy_o = busy_q;
  assign clr_o  = clr_q;
  assign done_o = done_q;

endmodule

// File: tb/tb_sha256_msg_sched.sv
module tb_sha256_msg_sched;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        word_valid_i;
  logic        word_ready_o;
  logic [31:0] word_i;
  logic        last_i;
  logic [31:0] w_o;
  logic [31:0] k_o;
  logic        clr_o;
  logic        update_o;
  logic        busy_o;
  logic        done_o;

  always #5 clk_i = ~clk_i;

  sha256_msg_sched dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .word_valid_i (word_valid_i),
    .word_ready_o (word_ready_o),
    .word_i       (word_i),
    .last_i       (last_i),
    .w_o          (w_o),
    .k_o          (k_o),
    .clr_o        (clr_o),
    .update_o     (update_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  localparam logic [31:0] IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };
  localparam logic [31:0] ABC_DIGEST [8] = '{
    32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
    32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Reference compression loop driven purely by the DUT's strobes.
  int          cyc = 0;
  int          clr_n = 0, upd_n = 0, done_n = 0, bad_rdy = 0;
  int          run_start = 0, prev_start = 0, upd_cyc = 0, done_cyc = 0, rc = 0;
  logic        busy_d = 1'b0;
  logic [31:0] hh [8];
  logic [31:0] wv [8];
  logic [31:0] digest [8];

  initial begin
    logic [31:0] s0, s1, ch, mj, t1, t2;
    hh = IV;
    wv = IV;
    for (int i = 0; i < 8; i++) digest[i] = 32'd0;
    forever begin
      @(negedge clk_i);
      cyc++;
      if (!rst_ni) begin
        busy_d = 1'b0;
      end else begin
        if (clr_o) begin
          clr_n++;
          hh = IV;
        end
        if (busy_o) begin
          if (word_ready_o) bad_rdy++;
          if (!busy_d) begin
            rc         = 0;
            prev_start = run_start;
            run_start  = cyc;
            wv         = hh;
          end
          if ((rc % 4) == 0) begin
            s1 = rotr(wv[4], 6) ^ rotr(wv[4], 11) ^ rotr(wv[4], 25);
            ch = (wv[4] & wv[5]) ^ (~wv[4] & wv[6]);
            t1 = wv[7] + s1 + ch + k_o + w_o;
            s0 = rotr(wv[0], 2) ^ rotr(wv[0], 13) ^ rotr(wv[0], 22);
            mj = (wv[0] & wv[1]) ^ (wv[0] & wv[2]) ^ (wv[1] & wv[2]);
            t2 = s0 + mj;
            wv[7] = wv[6]; wv[6] = wv[5]; wv[5] = wv[4]; wv[4] = wv[3] + t1;
            wv[3] = wv[2]; wv[2] = wv[1]; wv[1] = wv[0]; wv[0] = t1 + t2;
          end
          rc++;
        end
        if (update_o) begin
          upd_n++;
          upd_cyc = cyc;
          for (int i = 0; i < 8; i++) hh[i] = hh[i] + wv[i];
        end
        if (done_o) begin
          done_n++;
          done_cyc = cyc;
          digest   = hh;
        end
        busy_d = busy_o;
      end
    end
  end

  task automatic put_word(input logic [31:0] w, input logic l, input int gap);
    int guard;
    guard = 0;
    @(negedge clk_i);
    if (gap > 0) begin
      word_valid_i = 1'b0;
      repeat (gap) @(negedge clk_i);
    end
    word_valid_i = 1'b1;
    word_i       = w;
    last_i       = l;
    while (!word_ready_o && guard < 600) begin
      @(negedge clk_i);
      guard++;
    end
    if (guard >= 600) check("put_word_timeout", 32'd0, 32'd1);
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_done(input string name);
    int guard;
    guard = 0;
    @(negedge clk_i);
    while (!done_o && guard < 600) begin
      @(negedge clk_i);
      guard++;
    end
    word_valid_i = 1'b0;
    check(name, {31'd0, done_o}, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"},  {31'd0, word_ready_o}, 32'd1);
    check({tag, "_w"},      w_o, 32'd0);
    check({tag, "_k"},      k_o, 32'd0);
    check({tag, "_busy"},   {31'd0, busy_o}, 32'd0);
    check({tag, "_clr"},    {31'd0, clr_o}, 32'd0);
    check({tag, "_update"}, {31'd0, update_o}, 32'd0);
    check({tag, "_done"},   {31'd0, done_o}, 32'd0);
  endtask

  typedef struct {
    int          cyc;
    logic [31:0] w;
    logic [31:0] k;
    bit          chk_w;
    bit          chk_k;
    logic        busy;
    logic        upd;
    logic        done;
    logic        rdy;
  } vec_t;

  vec_t        vecs [12];
  logic [31:0] abc  [16];
  logic [31:0] m1   [16];
  int c, c0, u0, d0, b0;

  initial begin
    for (int i = 0; i < 16; i++) begin
      abc[i] = 32'd0;
      m1[i]  = 32'h01010101 * (i + 1);
    end
    abc[0]  = 32'h61626380;
    abc[15] = 32'h00000018;

    //            cyc  W[t]          K[t]          chkw chkk busy upd done rdy
    vecs[0]  = '{  0, 32'h61626380, 32'h428a2f98, 1, 1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{  3, 32'h61626380, 32'h428a2f98, 1, 1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{  4, 32'h00000000, 32'h71374491, 1, 1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{ 60, 32'h00000018, 32'hc19bf174, 1, 1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{ 63, 32'h00000018, 32'hc19bf174, 1, 1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{ 64, 32'h61626380, 32'he49b69c1, 1, 1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{ 67, 32'h61626380, 32'he49b69c1, 1, 1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{ 68, 32'h000f0000, 32'hefbe4786, 1, 1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{ 76, 32'h600003c6, 32'h240ca1cc, 1, 1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{252, 32'h00000000, 32'hc67178f2, 0, 1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{255, 32'h00000000, 32'hc67178f2, 0, 1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{256, 32'h00000000, 32'h00000000, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1};

    word_valid_i = 1'b0;
    word_i       = 32'd0;
    last_i       = 1'b0;
    rst_ni       = 1'b0;
    #12;
    check_reset_outputs("reset");
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Single "abc" chunk, table-driven timing checks.
    c0 = clr_n; u0 = upd_n; d0 = done_n;
    put_word(abc[0], 1'b0, 0);
    check("abc_clr_after_word0", {31'd0, clr_o}, 32'd1);
    for (int i = 1; i < 16; i++) put_word(abc[i], (i == 15), 0);
    word_valid_i = 1'b0;
    c = -1;
    for (int v = 0; v < 12; v++) begin
      while (c < vecs[v].cyc) begin
        @(negedge clk_i);
        c++;
      end
      if (vecs[v].chk_w) check($sformatf("abc_w_cyc%0d", vecs[v].cyc), w_o, vecs[v].w);
      if (vecs[v].chk_k) check($sformatf("abc_k_cyc%0d", vecs[v].cyc), k_o, vecs[v].k);
      check($sformatf("abc_busy_cyc%0d", vecs[v].cyc), {31'd0, busy_o}, {31'd0, vecs[v].busy});
      check($sformatf("abc_update_cyc%0d", vecs[v].cyc), {31'd0, update_o}, {31'd0, vecs[v].upd});
      check($sformatf("abc_done_cyc%0d", vecs[v].cyc), {31'd0, done_o}, {31'd0, vecs[v].done});
      check($sformatf("abc_ready_cyc%0d", vecs[v].cyc), {31'd0, word_ready_o}, {31'd0, vecs[v].rdy});
    end
    @(negedge clk_i);
    #1;
    check("abc_clr_count", clr_n - c0, 1);
    check("abc_update_count", upd_n - u0, 1);
    check("abc_done_count", done_n - d0, 1);
    for (int i = 0; i < 8; i++) check($sformatf("abc_digest_h%0d", i), digest[i], ABC_DIGEST[i]);

    // Two-chunk message, back to back; last_i deliberately high on words 0..14 of chunk 1.
    c0 = clr_n; u0 = upd_n; d0 = done_n; b0 = bad_rdy;
    for (int i = 0; i < 16; i++) put_word(m1[i], (i != 15), 0);
    for (int i = 0; i < 16; i++) put_word(abc[i], 1'b1, 0);
    wait_done("two_chunk_done_seen");
    @(negedge clk_i);
    #1;
    check("two_chunk_clr_count", clr_n - c0, 1);
    check("two_chunk_update_count", upd_n - u0, 2);
    check("two_chunk_done_count", done_n - d0, 1);
    check("two_chunk_period", run_start - prev_start, 272);
    check("two_chunk_done_after_update", done_cyc - upd_cyc, 1);
    check("two_chunk_ready_in_run", bad_rdy - b0, 0);

    // Stalled load of "abc": same schedule, so same digest; valid held high through RUN.
    c0 = clr_n; b0 = bad_rdy;
    for (int i = 0; i < 16; i++) put_word(abc[i], (i == 15), $urandom_range(0, 3));
    wait_done("stall_done_seen");
    @(negedge clk_i);
    #1;
    check("stall_clr_count", clr_n - c0, 1);
    check("stall_ready_in_run", bad_rdy - b0, 0);
    for (int i = 0; i < 8; i++) check($sformatf("stall_digest_h%0d", i), digest[i], ABC_DIGEST[i]);

    // Reset in cycle 100 of a run.
    for (int i = 0; i < 16; i++) put_word(abc[i], 1'b1, 0);
    word_valid_i = 1'b0;
    c = -1;
    while (c < 100) begin
      @(negedge clk_i);
      c++;
    end
    check("abort_busy_before_reset", {31'd0, busy_o}, 32'd1);
    u0 = upd_n; d0 = done_n;
    rst_ni = 1'b0;
    #1;
    check_reset_outputs("abort");
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (300) @(negedge clk_i);
    #1;
    check("abort_no_update", upd_n - u0, 0);
    check("abort_no_done", done_n - d0, 0);
    check("abort_idle_ready", {31'd0, word_ready_o}, 32'd1);
    put_word(abc[0], 1'b0, 0);
    word_valid_i = 1'b0;
    check("abort_clr_after_word0", {31'd0, clr_o}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
